// File: rtl/dll_pkg.sv
// Shared types for the DLL loop controller: FSM states, step directions and
// internal counter widths.
package dll_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } dll_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } step_dir_e;

    // Vote accumulator holds +/-15 (DECIM max), reversal counter up to 255.
    localparam int ACC_W = 5;
    localparam int REV_W = 8;

endpackage

// File: rtl/dll_lock_det.sv
// Lock detector: counts direction reversals of code steps and runs the
// DISABLED / ACQUIRE / LOCKED state machine.
module dll_lock_det
    import dll_pkg::*;
#(
    parameter int LOCK_CNT = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic step_up,
    input  logic step_dn,
    input  logic step_sat,
    output logic active,
    output logic locked
);

    localparam logic [REV_W-1:0] REV_MAX = REV_W'(LOCK_CNT);
    localparam logic [REV_W-1:0] REV_ONE = REV_W'(1);

    dll_state_e       state_reg, state_next;
    step_dir_e        prev_reg, prev_next, step_dir;
    logic [REV_W-1:0] rev_reg, rev_next;
    logic             locked_reg;

    always_comb begin
        step_dir   = NONE;
        state_next = state_reg;
        prev_next  = prev_reg;
        rev_next   = rev_reg;

        if (step_up) begin
            step_dir = UP;
        end else if (step_dn) begin
            step_dir = DOWN;
        end

        // A step with no predecessor only records its direction.
        if (step_dir != NONE) begin
            prev_next = step_dir;
            if (prev_reg != NONE) begin
                if (prev_reg != step_dir) begin
                    rev_next = (rev_reg == REV_MAX) ? rev_reg : rev_reg + REV_ONE;
                end else begin
                    rev_next = '0;
                end
            end
        end

        case (state_reg)
            DISABLED: begin
                state_next = ACQUIRE;
            end
            ACQUIRE: begin
                if (rev_next == REV_MAX) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (step_dir != NONE && (step_sat || prev_reg == step_dir)) begin
                    state_next = ACQUIRE;
                    prev_next  = NONE;
                    rev_next   = '0;
                end
            end
            default: begin
                state_next = DISABLED;
            end
        endcase

        if (!en) begin
            state_next = DISABLED;
            prev_next  = NONE;
            rev_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= DISABLED;
            prev_reg   <= NONE;
            rev_reg    <= '0;
            locked_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            prev_reg   <= prev_next;
            rev_reg    <= rev_next;
            locked_reg <= (state_next == LOCKED);
        end
    end

    assign active = (state_reg != DISABLED);
    assign locked = locked_reg;

endmodule

// File: rtl/dll_loop_ctrl.sv
// DLL loop controller: decimates phase-detector votes into saturating
// delay-code steps and reports lock from the step reversal pattern.
module dll_loop_ctrl
    import dll_pkg::*;
#(
    parameter int CODE_W    = 6,
    parameter int INIT_CODE = 32,
    parameter int DECIM     = 4,
    parameter int LOCK_CNT  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              pd_valid,
    input  logic              pd_late,
    output logic [CODE_W-1:0] code,
    output logic              code_upd,
    output logic              locked,
    output logic              sat
);

    localparam logic [CODE_W-1:0]       CODE_MAX  = '1;
    localparam logic [CODE_W-1:0]       CODE_ONE  = CODE_W'(1);
    localparam logic [CODE_W-1:0]       CODE_INIT = CODE_W'(INIT_CODE);
    localparam logic signed [ACC_W-1:0] ACC_ONE   = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] DECIM_POS = ACC_W'(DECIM);
    localparam logic signed [ACC_W-1:0] DECIM_NEG = -DECIM_POS;

    logic signed [ACC_W-1:0] acc_reg, acc_next, acc_sum;
    logic [CODE_W-1:0]       code_reg, code_next;
    logic                    code_upd_reg, code_upd_next;
    logic                    sat_reg, sat_next;
    logic                    active, vote, step_up, step_dn, step_sat;

    dll_lock_det #(
        .LOCK_CNT (LOCK_CNT)
    ) u_lock_det (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .step_up  (step_up),
        .step_dn  (step_dn),
        .step_sat (step_sat),
        .active   (active),
        .locked   (locked)
    );

    always_comb begin
        vote     = en && active && pd_valid;
        acc_sum  = pd_late ? (acc_reg + ACC_ONE) : (acc_reg - ACC_ONE);
        step_up  = vote && pd_late && (acc_sum == DECIM_POS);
        step_dn  = vote && !pd_late && (acc_sum == DECIM_NEG);
        step_sat = (step_up && code_reg == CODE_MAX) || (step_dn && code_reg == '0);

        acc_next      = acc_reg;
        code_next     = code_reg;
        code_upd_next = 1'b0;
        sat_next      = sat_reg;

        // Disabling clears loop history but deliberately keeps the code.
        if (!en) begin
            acc_next = '0;
            sat_next = 1'b0;
        end else if (step_up || step_dn) begin
            acc_next = '0;
            if (step_sat) begin
                sat_next = 1'b1;
            end else begin
                sat_next      = 1'b0;
                code_upd_next = 1'b1;
                code_next     = step_up ? (code_reg + CODE_ONE) : (code_reg - CODE_ONE);
            end
        end else if (vote) begin
            acc_next = acc_sum;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_reg      <= '0;
            code_reg     <= CODE_INIT;
            code_upd_reg <= 1'b0;
            sat_reg      <= 1'b0;
        end else begin
            acc_reg      <= acc_next;
            code_reg     <= code_next;
            code_upd_reg <= code_upd_next;
            sat_reg      <= sat_next;
        end
    end

    assign code     = code_reg;
    assign code_upd = code_upd_reg;
    assign sat      = sat_reg;

endmodule

// File: tb/tb_dll_loop_ctrl.sv
// Self-checking bench: two controllers (INIT_CODE 32 and 63) driven in
// parallel, compared every cycle against a behavioural model.
module tb_dll_loop_ctrl;

    localparam int CODE_MAX = 63;
    localparam int DECIM    = 4;
    localparam int LOCK_CNT = 8;

    typedef struct {
        int code;
        int acc;
        int rev;
        int prev;   // 0 none, +1 up, -1 down
        int st;     // 0 disabled, 1 acquire, 2 locked
        bit upd;
        bit sat;
        bit lck;
    } model_t;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       pd_valid;
    logic       pd_late;
    logic [5:0] code_a, code_b;
    logic       upd_a, upd_b, lock_a, lock_b, sat_a, sat_b;

    int     n_checks;
    int     n_fail;
    model_t ma, mb;

    dll_loop_ctrl dut_a (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .pd_valid (pd_valid),
        .pd_late  (pd_late),
        .code     (code_a),
        .code_upd (upd_a),
        .locked   (lock_a),
        .sat      (sat_a)
    );

    dll_loop_ctrl #(
        .INIT_CODE (63)
    ) dut_b (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .pd_valid (pd_valid),
        .pd_late  (pd_late),
        .code     (code_b),
        .code_upd (upd_b),
        .locked   (lock_b),
        .sat      (sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic model_t model_init(int init);
        model_t m;
        m.code = init;
        m.acc  = 0;
        m.rev  = 0;
        m.prev = 0;
        m.st   = 0;
        m.upd  = 0;
        m.sat  = 0;
        m.lck  = 0;
        return m;
    endfunction

    function automatic model_t model_next(model_t m, bit e, bit pv, bit pl);
        model_t n;
        int     step;
        bit     satd;
        bit     same;
        n     = m;
        step  = 0;
        n.upd = 0;
        if (!e) begin
            n.st = 0; n.acc = 0; n.rev = 0; n.prev = 0; n.sat = 0; n.lck = 0;
            return n;
        end
        if (m.st == 0) begin
            n.st  = 1;
            n.lck = 0;
            return n;
        end
        if (pv) begin
            n.acc = m.acc + (pl ? 1 : -1);
            if (n.acc == DECIM || n.acc == -DECIM) begin
                step  = pl ? 1 : -1;
                n.acc = 0;
            end
        end
        if (step != 0) begin
            satd = (m.code + step < 0) || (m.code + step > CODE_MAX);
            if (satd) begin
                n.sat = 1;
            end else begin
                n.code = m.code + step;
                n.upd  = 1;
                n.sat  = 0;
            end
            same = (m.prev == step);
            if (m.prev != 0)
                n.rev = same ? 0 : ((m.rev < LOCK_CNT) ? m.rev + 1 : m.rev);
            n.prev = step;
            if (m.st == 2 && (satd || same)) begin
                n.st = 1; n.prev = 0; n.rev = 0;
            end
        end
        if (m.st == 1 && n.rev == LOCK_CNT)
            n.st = 2;
        n.lck = (n.st == 2);
        return n;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a_code",   32'(code_a), ma.code);
        check("a_upd",    32'(upd_a),  32'(ma.upd));
        check("a_locked", 32'(lock_a), 32'(ma.lck));
        check("a_sat",    32'(sat_a),  32'(ma.sat));
        check("b_code",   32'(code_b), mb.code);
        check("b_upd",    32'(upd_b),  32'(mb.upd));
        check("b_locked", 32'(lock_b), 32'(mb.lck));
        check("b_sat",    32'(sat_b),  32'(mb.sat));
    endtask

    // Inputs change 1ns after a rising edge; outputs are compared at the same point.
    task automatic tick(bit e, bit pv, bit pl);
        en       = e;
        pd_valid = pv;
        pd_late  = pl;
        @(posedge clk);
        ma = model_next(ma, e, pv, pl);
        mb = model_next(mb, e, pv, pl);
        #1;
        compare_all();
    endtask

    task automatic votes(int n, bit pl);
        repeat (n) tick(1'b1, 1'b1, pl);
    endtask

    initial begin
        int bias;
        bit e, pv, pl;
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        en       = 1'b0;
        pd_valid = 1'b0;
        pd_late  = 1'b0;
        ma = model_init(32);
        mb = model_init(63);

        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("rst_code_a", 32'(code_a), 32);
        check("rst_code_b", 32'(code_b), 63);
        rstn = 1'b1;
        tick(1'b0, 1'b0, 1'b0);

        // First step up after enable
        tick(1'b1, 1'b0, 1'b0);
        votes(4, 1'b1);
        check("up_code_a", 32'(code_a), 33);
        check("up_upd_a",  32'(upd_a),  1);
        check("up_lock_a", 32'(lock_a), 0);
        check("sat_code_b", 32'(code_b), 63);
        check("sat_upd_b",  32'(upd_b),  0);
        check("sat_flag_b", 32'(sat_b),  1);
        tick(1'b1, 1'b0, 1'b0);
        check("upd_pulse_a", 32'(upd_a), 0);

        // Alternating early/late blocks: 8 reversals reach lock
        for (int blk = 0; blk < 8; blk++) begin
            votes(4, blk[0]);
            check("dither_code_a", 32'(code_a), blk[0] ? 33 : 32);
            if (blk == 0) begin
                check("unsat_code_b", 32'(code_b), 62);
                check("unsat_flag_b", 32'(sat_b),  0);
            end
            if (blk == 6)
                check("prelock_a", 32'(lock_a), 0);
        end
        check("lock_a", 32'(lock_a), 1);

        // Two same-direction steps drop lock
        votes(8, 1'b1);
        check("unlock_a",      32'(lock_a), 0);
        check("unlock_code_a", 32'(code_a), 35);

        // Dropping en clears the partial vote count
        votes(3, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        votes(1, 1'b1);
        check("en_clr_code_a", 32'(code_a), 35);
        check("en_clr_upd_a",  32'(upd_a),  0);

        // Async reset mid-step at code 40
        votes(19, 1'b1);
        check("pre_rst_code_a", 32'(code_a), 40);
        votes(3, 1'b1);
        rstn = 1'b0;
        #1;
        check("arst_code_a", 32'(code_a), 32);
        check("arst_lock_a", 32'(lock_a), 0);
        check("arst_code_b", 32'(code_b), 63);
        check("arst_sat_b",  32'(sat_b),  0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        ma = model_init(32);
        mb = model_init(63);
        tick(1'b1, 1'b0, 1'b0);
        votes(3, 1'b1);
        check("post_rst_code_a", 32'(code_a), 32);
        votes(1, 1'b1);
        check("post_rst_step_a", 32'(code_a), 33);

        // Randomised phase drift with occasional disables
        bias = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0)
                bias = int'($urandom_range(0, 100));
            e  = ($urandom_range(0, 39) != 0);
            pv = ($urandom_range(0, 1) == 1);
            pl = (int'($urandom_range(0, 99)) < bias);
            tick(e, pv, pl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
